// File: rtl/trig_mac_if.sv
// Sample-in / result-out bundle for the trig_mac multiply-add pipeline.
// The master drives samples and clear; the slave (the datapath) returns results.
interface trig_mac_if #(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned OUTSIZE = 16
);
    logic               in_valid;
    logic               mode;
    logic               clear;
    logic [SIZE-1:0]    A;
    logic [SIZE-1:0]    B;
    logic [SIZE-1:0]    C;
    logic [OUTSIZE-1:0] data_out;
    logic               out_valid;
    logic               sat;
    logic               busy;

    modport master (
        output in_valid, mode, clear, A, B, C,
        input  data_out, out_valid, sat, busy
    );

    modport slave (
        input  in_valid, mode, clear, A, B, C,
        output data_out, out_valid, sat, busy
    );
endinterface

// File: rtl/trig_mac.sv
// Two-stage valid-qualified A*B+C pipeline with optional ACC_LEN-sample accumulation,
// saturation to all-ones with a sticky per-frame overflow flag, and synchronous clear.
module trig_mac #(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned OUTSIZE = 16,
    parameter int unsigned ACC_LEN = 4
) (
    input  logic        clc,
    input  logic        rst,
    trig_mac_if.slave   bus
);

    localparam int unsigned CntW    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACC_LEN - 1);

    // Frame tracking
    logic [CntW-1:0]    cnt;
    logic               frame_mode;

    // Stage 1
    logic               s1_valid;
    logic               s1_first;
    logic               s1_last;
    logic [OUTSIZE-1:0] s1_prod;
    logic [SIZE-1:0]    s1_c;

    // Stage 2
    logic [OUTSIZE-1:0] acc;
    logic               ovf;
    logic               acc_active;
    logic [OUTSIZE-1:0] data_out_r;
    logic               out_valid_r;
    logic               sat_r;

    logic               eff_mode;
    logic               in_first;
    logic               in_last;
    logic [2*SIZE-1:0]  prod;
    logic [OUTSIZE-1:0] base;
    logic [OUTSIZE:0]   sum;
    logic               sum_ovf;
    logic [OUTSIZE-1:0] sum_sat;

    always_comb begin
        // The first sample of a frame uses the live mode; later samples use the latched one.
        eff_mode = (cnt == '0) ? bus.mode : frame_mode;
        in_first = !eff_mode || (cnt == '0);
        in_last  = !eff_mode || (cnt == CntLast);
        prod     = {{SIZE{1'b0}}, bus.A} * {{SIZE{1'b0}}, bus.B};
        base     = s1_first ? OUTSIZE'(s1_c) : acc;
        sum      = {1'b0, base} + {1'b0, s1_prod};
        sum_ovf  = sum[OUTSIZE];
        sum_sat  = sum_ovf ? '1 : sum[OUTSIZE-1:0];
    end

    always_ff @(posedge clc or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            frame_mode  <= 1'b0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_prod     <= '0;
            s1_c        <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
            acc_active  <= 1'b0;
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
        end else if (bus.clear) begin
            // data_out and sat deliberately hold across a clear.
            cnt         <= '0;
            s1_valid    <= 1'b0;
            acc         <= '0;
            ovf         <= 1'b0;
            acc_active  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            s1_valid    <= bus.in_valid;
            if (bus.in_valid) begin
                s1_prod  <= OUTSIZE'(prod);
                s1_c     <= bus.C;
                s1_first <= in_first;
                s1_last  <= in_last;
                if (cnt == '0) begin
                    frame_mode <= bus.mode;
                end
                cnt <= in_last ? '0 : cnt + CntW'(1);
            end
            if (s1_valid) begin
                if (s1_last) begin
                    data_out_r  <= sum_sat;
                    sat_r       <= ovf | sum_ovf;
                    out_valid_r <= 1'b1;
                    acc         <= '0;
                    ovf         <= 1'b0;
                    acc_active  <= 1'b0;
                end else begin
                    acc        <= sum_sat;
                    ovf        <= ovf | sum_ovf;
                    acc_active <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sat       = sat_r;
    assign bus.busy      = (cnt != '0) || s1_valid || acc_active;

endmodule

// File: tb/tb_trig_mac.sv
// Directed bench for trig_mac: mode-0 vector table plus hand-written frame, saturation,
// clear and reset sequences. Inputs change and outputs are sampled on the falling edge.
module tb_trig_mac;

    localparam int unsigned SIZE    = 8;
    localparam int unsigned OUTSIZE = 16;
    localparam int unsigned ACC_LEN = 4;

    logic clc = 1'b0;
    logic rst = 1'b0;
    always #5 clc = ~clc;

    trig_mac_if #(.SIZE(SIZE), .OUTSIZE(OUTSIZE)) bus ();

    trig_mac #(.SIZE(SIZE), .OUTSIZE(OUTSIZE), .ACC_LEN(ACC_LEN)) dut (
        .clc (clc),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step();
        @(negedge clc);
    endtask

    task automatic drive(input logic v, input logic m, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c, input logic clr);
        bus.in_valid = v;
        bus.mode     = m;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.clear    = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    // Four back-to-back mode-1 samples of (a,b); the result shows two edges after the last.
    task automatic frame_same(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [15:0] exp_data,
                              input logic exp_sat);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), a, b, (i == 0) ? c : 8'd77, 1'b0);
            step();
            check({name, " busy"}, bus.busy, 1);
            if (i < 3) check({name, " early out_valid"}, bus.out_valid, 0);
        end
        idle();
        check({name, " out_valid before latency"}, bus.out_valid, 0);
        step();
        check({name, " out_valid"}, bus.out_valid, 1);
        check({name, " data_out"}, bus.data_out, exp_data);
        check({name, " sat"}, bus.sat, exp_sat);
        check({name, " busy after result"}, bus.busy, 0);
        step();
        check({name, " out_valid pulse"}, bus.out_valid, 0);
        check({name, " sat holds"}, bus.sat, exp_sat);
        check({name, " data_out holds"}, bus.data_out, exp_data);
    endtask

    initial begin
        vecs[0] = '{a: 8'd3,   b: 8'd4,   c: 8'd5,   exp_data: 16'd17,    exp_sat: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, exp_data: 16'd65280, exp_sat: 1'b0};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   exp_data: 16'd0,     exp_sat: 1'b0};
        vecs[3] = '{a: 8'd0,   b: 8'd9,   c: 8'd200, exp_data: 16'd200,   exp_sat: 1'b0};
        vecs[4] = '{a: 8'd16,  b: 8'd16,  c: 8'd7,   exp_data: 16'd263,   exp_sat: 1'b0};

        idle();
        rst = 1'b0;
        step();
        step();
        check("reset data_out", bus.data_out, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset sat", bus.sat, 0);
        check("reset busy", bus.busy, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle out_valid", bus.out_valid, 0);
        end
        check("idle busy", bus.busy, 0);

        // Mode 0 single-shot table
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
            step();
            idle();
            check("m0 latency", bus.out_valid, 0);
            step();
            check("m0 out_valid", bus.out_valid, 1);
            check("m0 data_out", bus.data_out, vecs[i].exp_data);
            check("m0 sat", bus.sat, vecs[i].exp_sat);
            step();
            check("m0 pulse", bus.out_valid, 0);
        end

        // Mode 0 stream: A=1,2,3, B=2, C=1 -> 3,5,7 on consecutive cycles
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc < 3) drive(1'b1, 1'b0, 8'(cyc + 1), 8'd2, 8'd1, 1'b0);
            else idle();
            step();
            if (cyc >= 1 && cyc <= 3) begin
                check("stream out_valid", bus.out_valid, 1);
                check("stream data_out", bus.data_out, 32'(2 * cyc + 1));
            end else begin
                check("stream gap", bus.out_valid, 0);
            end
        end
        idle();
        step();

        // Mode 1 frame with gaps; later C and mode must be ignored: 10+2+12+30+56 = 110
        begin
            logic [7:0] fa [4];
            logic [7:0] fb [4];
            logic [7:0] fc [4];
            fa = '{8'd1, 8'd3, 8'd5, 8'd7};
            fb = '{8'd2, 8'd4, 8'd6, 8'd8};
            fc = '{8'd10, 8'd99, 8'd50, 8'd33};
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, (i == 0), fa[i], fb[i], fc[i], 1'b0);
                step();
                idle();
                check("frame busy", bus.busy, 1);
                check("frame no early out", bus.out_valid, 0);
                if (i < 3) begin
                    for (int g = 0; g < 2; g++) begin
                        step();
                        check("frame gap busy", bus.busy, 1);
                        check("frame gap out_valid", bus.out_valid, 0);
                    end
                end
            end
            step();
            check("frame out_valid", bus.out_valid, 1);
            check("frame data_out", bus.data_out, 110);
            check("frame sat", bus.sat, 0);
            check("frame busy clear", bus.busy, 0);
            step();
            check("frame pulse", bus.out_valid, 0);
        end

        frame_same("sat", 8'd255, 8'd255, 8'd0, 16'd65535, 1'b1);
        frame_same("post-sat", 8'd1, 8'd1, 8'd0, 16'd4, 1'b0);

        // Clear after two samples, then a fresh frame
        drive(1'b1, 1'b1, 8'd9, 8'd9, 8'd3, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'd9, 8'd9, 8'd3, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        step();
        idle();
        check("clear busy", bus.busy, 0);
        check("clear out_valid", bus.out_valid, 0);
        check("clear data_out holds", bus.data_out, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("after clear out_valid", bus.out_valid, 0);
        end
        frame_same("post-clear", 8'd2, 8'd2, 8'd1, 16'd17, 1'b0);

        // Clear coinciding with a sample drops it
        drive(1'b1, 1'b0, 8'd100, 8'd100, 8'd1, 1'b1);
        step();
        idle();
        check("clear+sample busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("clear+sample out_valid", bus.out_valid, 0);
            step();
        end
        check("clear+sample data holds", bus.data_out, 17);

        // Reset mid-frame
        drive(1'b1, 1'b1, 8'd5, 8'd5, 8'd5, 1'b0);
        step();
        step();
        idle();
        #2 rst = 1'b0;
        #1;
        check("midrst data_out", bus.data_out, 0);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst sat", bus.sat, 0);
        check("midrst busy", bus.busy, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post-rst out_valid", bus.out_valid, 0);
        end
        check("post-rst busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trig_mac.md
# trig_mac

Parametrised, valid-qualified multiply-add pipeline. It is the next generation of the team's fixed A*B+C stage. It adds an input/output valid handshake, a configurable accumulate mode that sums ACC_LEN products into one result, saturation with an overflow flag, and a synchronous frame clear. It sits in the datapath between sample sources and downstream result registers. All widths come from parameters.

## Interface
- SIZE, 8, width of operands A, B, C (unsigned)
- OUTSIZE, 16, result width; must be >= 2*SIZE
- ACC_LEN, 4, products per frame in accumulate mode; must be >= 1
- clc  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  A/B/C/mode sample valid this cycle
- mode  in  1  0 = single A*B+C, 1 = accumulate frame; sampled only on the first sample of a frame
- clear  in  1  synchronous abort of the current frame and in-flight data
- A, B, C  in  SIZE each  unsigned operands
- data_out  out  OUTSIZE  result; holds its value between out_valid pulses
- out_valid  out  1  one-cycle pulse, data_out is new
- sat  out  1  valid with out_valid: result was clamped to all-ones
- busy  out  1  high while a mode-1 frame is partially accepted or any sample is in flight

## Operation
- **Stage 1 (input register):** on in_valid, registers:
  - prod = A*B (2*SIZE bits, zero-extended to OUTSIZE)
  - C
  - valid
  - the frame's latched mode
  - first/last flags
- **Frame counter cnt** (0..ACC_LEN-1):
  - mode is latched when a sample is accepted with cnt==0.
  - In mode 0, every sample has first = last = 1, and cnt stays 0.
  - In mode 1:
    - first = (cnt==0) and last = (cnt==ACC_LEN-1).
    - cnt increments per accepted sample and wraps to 0 after last.
    - With ACC_LEN=1, mode 1 behaves like mode 0.
- **Gaps:** in_valid low cycles are allowed anywhere. Nothing advances, and cnt and the accumulator hold.
- **Stage 2 (output / accumulate):** on a stage-1 valid:
  - The sum base is C if first, else acc.
  - sum = base + prod, computed at OUTSIZE+1 bits.
  - On overflow (bit OUTSIZE set), sum clamps to 2^OUTSIZE-1 and the sticky frame overflow bit ovf sets.
  - If last: data_out <= sum, sat <= ovf (including this step), out_valid <= 1, and acc and ovf clear.
  - Otherwise: acc <= sum, and out_valid stays 0.
- **C handling:** C is used only on the first sample of a frame. C on later samples is ignored.
- **Frame mode:** mode changes mid-frame are ignored until the frame completes.
- **clear:**
  - Next edge: cnt, acc and ovf go to 0, the stage-1 valid is killed, and out_valid is 0.
  - data_out and sat hold.
  - If clear and in_valid are high together, clear wins and that sample is dropped.
- **busy** = (cnt != 0) OR stage-1 valid OR a mode-1 frame accumulating in stage 2.

## Timing
- **Reset (rst low, asynchronous):** data_out=0, out_valid=0, sat=0, busy=0. Internally, cnt=0, acc=0, ovf=0 and the stage-1 valid=0. Reset mid-frame discards the frame, with no output.
- **Latency:**
  - In mode 0, out_valid rises 2 clocks after the in_valid edge.
  - In mode 1, out_valid rises 2 clocks after the sample with cnt==ACC_LEN-1 is accepted.
- **Throughput:** one sample per clock, back-to-back, with no stall. Mode 0 gives one result per clock.
- **Outputs:**
  - out_valid is a single-cycle pulse.
  - sat is meaningful only with out_valid and holds otherwise.
  - data_out changes only in the same cycle out_valid is high.
- **Frame boundaries:** frames may be back-to-back. The next frame's first sample may be accepted on the cycle after the last sample of the previous frame.

## Test plan
- **Reset values:** hold rst low, then release with no stimulus -> data_out=0, out_valid=0, sat=0, busy=0; out_valid never pulses.
- **Mode 0 single:**
  - Stimulus: A=3, B=4, C=5 for one cycle.
  - Response: out_valid pulses 2 clocks later with data_out=17 and sat=0. A max case A=B=C=255 gives 65280 with sat=0.
- **Mode 0 stream:**
  - Stimulus: A=1,2,3 with B=2, C=1 on consecutive cycles.
  - Response: data_out = 3, 5, 7 on 3 consecutive out_valid cycles.
- **Mode 1 frame, ACC_LEN=4:**
  - Stimulus: (1,2,C=10), (3,4,C=99), (5,6), (7,8), with 2 idle cycles between samples.
  - Response: no out_valid until 2 clocks after the 4th sample; then data_out=110, sat=0. busy is high from the first sample until out_valid.
- **Saturation:**
  - Stimulus: mode 1 with A=B=255 for 4 samples, C=0.
  - Response: data_out=65535, sat=1.
  - Follow-up: a new frame of 4×(1,1), C=0 -> 4 with sat=0.
- **Clear and reset mid-frame:**
  - Mode 1, clear after 2 samples, then a fresh frame of 4×(2,2) with C=1 -> only result 17 appears.
  - Driving clear together with a sample drops that sample.
  - Asserting rst mid-frame -> no output, and all outputs read 0.
